dmem_waitstate: RTL

- Data memory for the pipelined ARM core, sitting directly downstream of the core's Memory stage.
- Consumes the core's memory-stage outputs: address, store data, write strobe and byte/word select.
- Returns load data.
- Models a slow memory with a configurable number of wait states and raises a stall to freeze the pipeline while an access is in flight.

---
 rtl/dmem_if.sv | 27 ++
 rtl/dmem_waitstate.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// +--------------------------------------------------------------------------+
// | dmem_if : memory-stage request/response bundle for dmem_waitstate  r1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface dmem_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic        BEDmem;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        MemErrM;

  modport master (
    output MemReadM, MemWriteM, BEDmem, ALUResultM, WriteDataM,
    input  ReadDataM, StallMem, MemErrM
  );

  modport slave (
    input  MemReadM, MemWriteM, BEDmem, ALUResultM, WriteDataM,
    output ReadDataM, StallMem, MemErrM
  );
endinterface

`default_nettype wire

// File: rtl/dmem_waitstate.sv
// +--------------------------------------------------------------------------+
// | dmem_waitstate : wait-stated data memory with pipeline stall     r1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_waitstate #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  dmem_if.slave     bus
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] c_BYTES    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  c_CNT_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_stall, w_commit;
  logic [31:0] r_rdata;
  logic        r_err;

  logic          w_req, w_oor;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic [31:0]   w_word, w_byte_ld;

  logic [31:0] r_mem [DEPTH_WORDS];

  assign w_req     = bus.MemReadM | bus.MemWriteM;
  assign w_oor     = (bus.ALUResultM >= c_BYTES);
  assign w_idx     = bus.ALUResultM[AW+1:2];
  assign w_lane    = bus.ALUResultM[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_byte_ld = {24'd0, w_word[{w_lane, 3'b000} +: 8]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The access commits on the last WAIT edge; DONE only presents the result.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = c_CNT_INIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A reset on the commit edge discards the store.
  always_ff @(posedge clk) begin
    if (reset && w_commit && bus.MemWriteM && !w_oor) begin
      if (bus.BEDmem) begin
        r_mem[w_idx][{w_lane, 3'b000} +: 8] <= bus.WriteDataM[7:0];
      end else begin
        r_mem[w_idx] <= bus.WriteDataM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_commit & w_oor;
      if (w_commit) begin
        if (bus.MemWriteM) begin
          if (bus.MemReadM) begin
            r_rdata <= 32'd0;
          end
        end else if (w_oor) begin
          r_rdata <= 32'd0;
        end else begin
          r_rdata <= bus.BEDmem ? w_byte_ld : w_word;
        end
      end
    end
  end

  assign bus.StallMem  = w_stall;
  assign bus.ReadDataM = r_rdata;
  assign bus.MemErrM   = r_err;

endmodule

`default_nettype wire
